mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's load/store and fetch port. It accepts one request at a time from the datapath/controller over a valid/ready handshake and returns a one-cycle response pulse carrying read data or a write acknowledge. It adds a configurable number of wait states before each access. Requests go either to the synchronous block RAM or to a small memory-mapped I/O bank holding LEDs, switches and a cycle counter.

---
 rtl/mem_responder.sv | 168 ++++++++++++++++
 tb/tb_mem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: one valid/ready request at a time, optional wait states,
// block RAM or MMIO (LEDs, switches, cycle counter) target. MMIO decode built only with `MMIO_EN.
module mem_responder #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 16,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [ADDR_W-1:0] MMIO_BASE   = 16'hFF00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [9:0]        io_sw,
  output logic [9:0]        io_led
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACCESS  = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wait;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_is_mmio;
  logic [DATA_W-1:0] w_mmio_rdata;
  logic [DATA_W-1:0] w_capture_data;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid & req_ready;

  // Request latch and sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wait  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wait  <= WAIT_INIT;
            r_state <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          r_wait <= r_wait - 4'd1;
          if (r_wait <= 4'd1) begin
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS:  r_state <= S_CAPTURE;
        S_CAPTURE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Writes always return zero; reads pick the MMIO bank or the RAM port
  always_comb begin
    w_capture_data = '0;
    if (!r_we) begin
      w_capture_data = w_is_mmio ? w_mmio_rdata : mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (r_state == S_CAPTURE) begin
        r_resp_valid <= 1'b1;
        r_rdata      <= w_capture_data;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  // Combinational so the strobe follows the state register even in a reset cycle
  assign mem_we     = (r_state == S_ACCESS) && r_we && !w_is_mmio;

`ifdef MMIO_EN
  logic [ADDR_W-1:0] w_off;
  logic [7:0]        w_off8;
  logic              w_mmio_we;
  logic [15:0]       w_mmio16;
  logic [9:0]        r_led;
  logic [9:0]        r_sw_meta;
  logic [9:0]        r_sw_sync;
  logic [15:0]       r_cnt;

  // Full-width window check; the window never wraps past the top of the address space
  assign w_off     = r_addr - MMIO_BASE;
  assign w_is_mmio = (r_addr >= MMIO_BASE) && ((w_off >> 8) == '0);
  assign w_off8    = w_off[7:0];
  assign w_mmio_we = (r_state == S_ACCESS) && r_we && w_is_mmio;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_cnt     <= '0;
    end else begin
      r_sw_meta <= io_sw;
      r_sw_sync <= r_sw_meta;
      if (w_mmio_we && (w_off8 == 8'd2)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_mmio_we && (w_off8 == 8'd0)) begin
        r_led <= r_wdata[9:0];
      end
    end
  end

  always_comb begin
    w_mmio16 = '0;
    case (w_off8)
      8'd0:    w_mmio16 = {6'd0, r_led};
      8'd1:    w_mmio16 = {6'd0, r_sw_sync};
      8'd2:    w_mmio16 = r_cnt;
      default: w_mmio16 = '0;
    endcase
  end

  assign w_mmio_rdata = DATA_W'(w_mmio16);
  assign io_led       = r_led;
`else
  logic w_unused_sw;

  assign w_is_mmio    = 1'b0;
  assign w_mmio_rdata = '0;
  assign io_led       = '0;
  assign w_unused_sw  = ^{io_sw, MMIO_BASE};
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with no wait states, one with three.
// MMIO checks are compiled in when MMIO_EN is defined, RAM-only checks otherwise.
module tb_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_we     [2];
  logic [15:0] req_addr   [2];
  logic [15:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [15:0] resp_rdata [2];
  logic [15:0] mem_addr   [2];
  logic        mem_we     [2];
  logic [15:0] mem_wdata  [2];
  logic [15:0] mem_rdata  [2];
  logic [9:0]  io_led     [2];
  logic [9:0]  io_sw;

  logic [15:0] ram0 [0:65535];
  logic [15:0] ram1 [0:65535];

  mem_responder #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(0), .MMIO_BASE(16'hFF00)) u_dut0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .mem_addr(mem_addr[0]),
    .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .io_sw(io_sw), .io_led(io_led[0])
  );

  mem_responder #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3), .MMIO_BASE(16'hFF00)) u_dut1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .mem_addr(mem_addr[1]),
    .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .io_sw(io_sw), .io_led(io_led[1])
  );

  // Synchronous block RAM models: read data one cycle after the address
  always @(posedge clk) begin
    if (mem_we[0]) ram0[mem_addr[0]] <= mem_wdata[0];
    mem_rdata[0] <= ram0[mem_addr[0]];
    if (mem_we[1]) ram1[mem_addr[1]] <= mem_wdata[1];
    mem_rdata[1] <= ram1[mem_addr[1]];
  end

  typedef struct {
    string       nm;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_wep;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic we, logic [15:0] a, logic [15:0] wd,
                              logic [15:0] er, int ew);
    vec_t v;
    v.nm = nm; v.we = we; v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_wep = ew;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Single request; lat counts edges from acceptance to the response pulse
  task automatic do_req(input int d, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, output logic [15:0] rdata,
                        output int lat, output int wep, output logic [15:0] wa,
                        output logic after);
    int n;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 0; wep = 0; wa = '0;
    while (!resp_valid[d] && lat < 50) begin
      if (mem_we[d]) begin
        wep++;
        wa = mem_addr[d];
      end
      @(negedge clk);
      lat++;
    end
    rdata = resp_rdata[d];
    @(negedge clk);
    after = resp_valid[d];
  endtask

  // Two requests with req_valid held high; k0/k1 are negedge indices of the responses
  task automatic b2b(input int d, input logic we_a, input logic [15:0] a_a, input logic [15:0] wd_a,
                     input logic we_b, input logic [15:0] a_b, input logic [15:0] wd_b,
                     output logic [15:0] r0, output logic [15:0] r1,
                     output int k0, output int k1, output int low);
    int acc;
    int nresp;
    logic swd;
    acc = 0; nresp = 0; swd = 1'b0; k0 = 999; k1 = 999; low = 0; r0 = '0; r1 = '0;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we_a; req_addr[d] = a_a; req_wdata[d] = wd_a;
    for (int c = 0; c < 60 && nresp < 2; c++) begin
      if (resp_valid[d]) begin
        if (nresp == 0) begin r0 = resp_rdata[d]; k0 = c; end
        else begin r1 = resp_rdata[d]; k1 = c; end
        nresp++;
      end
      if (nresp == 0 && c > 0 && !req_ready[d]) low++;
      if (acc == 1 && !swd) begin
        swd = 1'b1;
        req_we[d] = we_b; req_addr[d] = a_b; req_wdata[d] = wd_b;
      end
      if (acc == 2) req_valid[d] = 1'b0;
      if (req_valid[d] && req_ready[d]) acc++;
      @(negedge clk);
    end
    req_valid[d] = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] wa;
    logic [15:0] r0;
    logic [15:0] r1;
    logic        after;
    int          lat;
    int          wep;
    int          k0;
    int          k1;
    int          low;
    int          nv;
    int          nw;

    io_sw = 10'h155;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready%0d", d), req_ready[d], 1);
      chk($sformatf("rst_resp_valid%0d", d), resp_valid[d], 0);
      chk($sformatf("rst_resp_rdata%0d", d), resp_rdata[d], 0);
      chk($sformatf("rst_mem_we%0d", d), mem_we[d], 0);
      chk($sformatf("rst_mem_addr%0d", d), mem_addr[d], 0);
      chk($sformatf("rst_mem_wdata%0d", d), mem_wdata[d], 0);
      chk($sformatf("rst_io_led%0d", d), io_led[d], 0);
    end

    vecs.push_back(mk("wr_0010", 1'b1, 16'h0010, 16'h1234, 16'h0000, 1));
    vecs.push_back(mk("rd_0010", 1'b0, 16'h0010, 16'h0000, 16'h1234, 0));
    vecs.push_back(mk("wr_0011", 1'b1, 16'h0011, 16'h00FF, 16'h0000, 1));
    vecs.push_back(mk("rd_0011", 1'b0, 16'h0011, 16'h0000, 16'h00FF, 0));
    vecs.push_back(mk("rd_0010b", 1'b0, 16'h0010, 16'h0000, 16'h1234, 0));
    vecs.push_back(mk("wr_FEFF", 1'b1, 16'hFEFF, 16'hA5A5, 16'h0000, 1));
    vecs.push_back(mk("rd_FEFF", 1'b0, 16'hFEFF, 16'h0000, 16'hA5A5, 0));
`ifdef MMIO_EN
    vecs.push_back(mk("wr_led", 1'b1, 16'hFF00, 16'h03FF, 16'h0000, 0));
    vecs.push_back(mk("rd_led", 1'b0, 16'hFF00, 16'h0000, 16'h03FF, 0));
    vecs.push_back(mk("rd_sw", 1'b0, 16'hFF01, 16'h0000, 16'h0155, 0));
    vecs.push_back(mk("wr_sw", 1'b1, 16'hFF01, 16'h2222, 16'h0000, 0));
    vecs.push_back(mk("rd_sw2", 1'b0, 16'hFF01, 16'h0000, 16'h0155, 0));
    vecs.push_back(mk("rd_FF07", 1'b0, 16'hFF07, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk("wr_FF07", 1'b1, 16'hFF07, 16'h1111, 16'h0000, 0));
    vecs.push_back(mk("rd_FF07b", 1'b0, 16'hFF07, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk("rd_FFFF", 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 0));
`else
    vecs.push_back(mk("wr_FF00", 1'b1, 16'hFF00, 16'hBEEF, 16'h0000, 1));
    vecs.push_back(mk("rd_FF00", 1'b0, 16'hFF00, 16'h0000, 16'hBEEF, 0));
    vecs.push_back(mk("wr_FFFF", 1'b1, 16'hFFFF, 16'h7777, 16'h0000, 1));
    vecs.push_back(mk("rd_FFFF", 1'b0, 16'hFFFF, 16'h0000, 16'h7777, 0));
`endif

    foreach (vecs[i]) begin
      do_req(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat, wep, wa, after);
      chk({vecs[i].nm, "_rdata"}, rd, vecs[i].exp_rdata);
      chk({vecs[i].nm, "_lat"}, lat, 2);
      chk({vecs[i].nm, "_wep"}, wep, vecs[i].exp_wep);
      if (vecs[i].exp_wep == 1) chk({vecs[i].nm, "_we_addr"}, wa, vecs[i].addr);
      chk({vecs[i].nm, "_pulse"}, after, 0);
    end

`ifdef MMIO_EN
    chk("led_after_table", io_led[0], 10'h3FF);
    b2b(0, 1'b0, 16'hFF02, 16'h0000, 1'b0, 16'hFF02, 16'h0000, r0, r1, k0, k1, low);
    chk("cnt_b2b_delta", r1 - r0, 3);
    chk("cnt_b2b_spacing", k1 - k0, 3);
    b2b(0, 1'b1, 16'hFF02, 16'h5555, 1'b0, 16'hFF02, 16'h0000, r0, r1, k0, k1, low);
    chk("cnt_clr_wr_rdata", r0, 0);
    chk("cnt_after_clear", r1, 3);
`else
    chk("led_tied_zero", io_led[0], 0);
`endif

    // Wait-state instance: latency, held request, ready gap
    do_req(1, 1'b1, 16'h0005, 16'h5A5A, rd, lat, wep, wa, after);
    chk("w3_wr_lat", lat, 5);
    chk("w3_wr_wep", wep, 1);
    chk("w3_wr_pulse", after, 0);
    b2b(1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h0005, 16'h0000, r0, r1, k0, k1, low);
    chk("w3_rd0", r0, 16'h5A5A);
    chk("w3_rd1", r1, 16'h5A5A);
    chk("w3_first_resp", k0, 6);
    chk("w3_spacing", k1 - k0, 6);
    chk("w3_ready_low", low, 5);

    // Reset during WAIT of an LED write aborts it
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 16'hFF00; req_wdata[1] = 16'h03FF;
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("rstw_ready", req_ready[1], 1);
    nv = 0; nw = 0;
    for (int c = 0; c < 10; c++) begin
      if (resp_valid[1]) nv++;
      if (mem_we[1]) nw++;
      @(negedge clk);
    end
    chk("rstw_no_resp", nv, 0);
    chk("rstw_no_mem_we", nw, 0);
    chk("rstw_led", io_led[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
